inst_mem_responder: RTL
=======================

Name: inst_mem_responder

Overview:
- Responder side of the instruction-fetch interface: serves the IF stage's fetch requests (word address in, instruction word out, stall request back).
- Fetches each 32-bit instruction from a byte-wide external memory port as four little-endian byte reads.
- Holds a one-entry word buffer so a repeat fetch of the same word skips memory.
- Sits between the IF stage and the memory/ROM arbiter.

Parameters:
- ADDR_W, 32, width of fetch and memory byte addresses.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  IF presents a fetch request; held with req_addr_i stable while busy_o=1.
- req_addr_i  in  ADDR_W  fetch address (pc); bits [1:0] ignored.
- flush_i  in  1  abort any in-flight fetch (branch redirect).
- inval_i  in  1  invalidate the word buffer.
- rdata_o  out  32  assembled instruction word.
- rdata_valid_o  out  1  one-cycle pulse: rdata_o is valid.
- busy_o  out  1  stall request to IF.
- mem_rd_o  out  1  byte read request to memory.
- mem_addr_o  out  ADDR_W  byte address of the current read.
- mem_rdata_i  in  8  byte returned by memory.
- mem_ready_i  in  1  mem_rdata_i is valid for mem_addr_o in this cycle.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, byte counter=0, buffer invalid, rdata_o=0, rdata_valid_o=0.
- While rst=1: busy_o=0, mem_rd_o=0, mem_addr_o=0.
- Reset mid-fetch discards the fetch; no response is produced.
- base = {req_addr_i[ADDR_W-1:2], 2'b00}, captured on accept.
- hit = buf_valid && buf_addr == {req_addr_i[ADDR_W-1:2], 2'b00}.
- State IDLE:
  - If req_valid_i && !flush_i && hit: load rdata_o from the buffer and go to RESP (1-cycle latency, no memory access).
  - If req_valid_i && !flush_i && !hit: capture base, cnt=0, go to READ.
- State READ:
  - mem_rd_o=1; mem_addr_o = base | cnt (cnt is 2 bits).
  - When mem_ready_i=1: write mem_rdata_i into byte lane cnt (lane 0 = bits [7:0]) and increment cnt.
  - When mem_ready_i=0: hold cnt and address; the byte is not sampled.
  - On the ready cycle with cnt=3: load rdata_o with the assembled word, set buf_addr=base and buf_valid=1, go to RESP.
- State RESP: rdata_valid_o=1, busy_o=0, no new request accepted; next state IDLE.
- rdata_valid_o is high only in RESP.
- rdata_o holds its value until the next load.
- Outside READ: mem_rd_o=0 and mem_addr_o=0.
- busy_o = (state==READ) || (state==IDLE && req_valid_i && !flush_i).
- Latency from the accept cycle: hit, valid 1 cycle later; miss with no wait states, valid 5 cycles later (READ for cycles 1–4, RESP in cycle 5).
- flush_i in any state: next state IDLE, cnt=0, no rdata_valid_o pulse for the aborted fetch, buffer unchanged.
  - flush_i during RESP: the pulse in that cycle still occurs; IF ignores it.
- inval_i: clears buf_valid next cycle.
  - If inval_i coincides with the buffer fill, inval_i wins (buf_valid=0).
  - If inval_i coincides with a hit lookup, the lookup uses the pre-invalidate buffer.
- Requests with req_valid_i=0 in IDLE: stay in IDLE, busy_o=0.
- Address wrap: only the low two bits step, so a fetch never crosses a word boundary.

Test Plan:
- Reset: hold rst 2 cycles mid-READ -> rdata_o=0, rdata_valid_o=0, busy_o=0, mem_rd_o=0; afterwards IDLE and buffer invalid (a fetch of 0x100 misses).
- Miss: req 0x100, memory bytes 0x13,0x05,0x10,0x00 at 0x100..0x103, ready=1 -> mem_addr_o=0x100..0x103 in cycles 1–4, busy_o=1 in cycles 0–4, rdata_o=0x00100513 with rdata_valid_o=1 in cycle 5 only.
- Hit: after the miss, req 0x100 again -> mem_rd_o stays 0, rdata_valid_o=1 one cycle later with 0x00100513. Then inval_i, then req 0x100 -> full 4-byte miss.
- Wait states: req 0x200, mem_ready_i=0 for 2 cycles while mem_addr_o=0x201 -> address holds 0x201, valid in cycle 7, correct word.
- Flush: req 0x300, flush_i in cycle 2 -> no valid pulse, mem_rd_o=0 from cycle 3. Next req 0x300 misses again; buffer still hits 0x200.
- Misaligned: req 0x402 -> reads 0x400..0x403, word assembled from byte 0x400 upward.

Source files
------------

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: serves IF fetches by assembling 4 little-endian byte reads, with a one-word buffer
module inst_mem_responder #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              flush_i,
  input  logic              inval_i,
  output logic [31:0]       rdata_o,
  output logic              rdata_valid_o,
  output logic              busy_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_ready_i
);
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
  state_t state, state_n;
  logic [1:0] cnt;
  logic [ADDR_W-1:2] base, buf_addr;
  logic buf_valid;
  logic [31:0] buf_data, asm_q, word;
  logic hit, accept, fill, unused_ok;
  assign unused_ok = &{1'b0, req_addr_i[1:0]};
  always_comb begin
    hit = buf_valid && buf_addr == req_addr_i[ADDR_W-1:2];
    accept = state == IDLE && req_valid_i && !flush_i;
    fill = state == READ && mem_ready_i && cnt == 2'd3 && !flush_i;
    word = {mem_rdata_i, asm_q[23:0]};
    state_n = flush_i ? IDLE : accept ? (hit ? RESP : READ) : fill ? RESP : state == RESP ? IDLE : state;
    mem_rd_o = !rst && state == READ;
    mem_addr_o = mem_rd_o ? {base, cnt} : '0;
    busy_o = !rst && (state == READ || accept);
    rdata_valid_o = !rst && state == RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      buf_valid <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      base <= '0;
      asm_q <= '0;
      rdata_o <= '0;
    end else begin
      state <= state_n;
      if (accept) base <= req_addr_i[ADDR_W-1:2];
      if (flush_i || accept) cnt <= '0;
      else if (state == READ && mem_ready_i) begin
        cnt <= cnt + 2'd1;
        asm_q[{cnt, 3'b000} +: 8] <= mem_rdata_i;
      end
      if (accept && hit) rdata_o <= buf_data;
      if (fill) begin
        rdata_o <= word;
        buf_data <= word;
        buf_addr <= base;
      end
      // invalidate beats a same-cycle fill
      buf_valid <= inval_i ? 1'b0 : fill ? 1'b1 : buf_valid;
    end
  end
endmodule
